inst_decoder: RTL

//  Front-end stage between instruction fetch and the register file (rf).

---
 rtl/inst_decoder_pkg.sv | 168 ++++++++++++++++
 rtl/inst_decoder_fifo.sv | 56 +++++
 rtl/inst_decoder.sv | 70 +++++++
 3 files changed

// File: rtl/inst_decoder_pkg.sv
// Purpose : shared constants, op encodings and the RV32I field decoder for inst_decoder.
// Latency : n/a (types, constants and a pure combinational function).
// Backpr. : n/a.
package inst_decoder_pkg;

    localparam int QueueDepth  = 16;
    localparam int QueuePtrLen = 4;
    localparam int RegIdLength = 4;
    localparam int OpLength    = 6;

    // RV32I major opcodes, inst[6:0]
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    typedef enum logic [OpLength-1:0] {
        OpNop = 6'd0,
        OpLui, OpAuipc, OpJal, OpJalr,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpLb, OpLh, OpLw, OpLbu, OpLhu,
        OpSb, OpSh, OpSw,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
    } op_e;

    typedef struct packed {
        logic                 vld;
        op_e                  op;
        logic [RegIdLength:0] rd;
        logic [RegIdLength:0] rs1;
        logic [RegIdLength:0] rs2;
        logic [31:0]          imm;
    } dec_t;

    // Field decode of one instruction word. vld=0 marks an unknown opcode/funct,
    // in which case the remaining fields are don't-care.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        d  = '0;
        f3 = inst[14:12];
        f7 = inst[31:25];
        case (inst[6:0])
            OpcLui, OpcAuipc: begin
                d.vld = 1'b1;
                d.op  = (inst[6:0] == OpcLui) ? OpLui : OpAuipc;
                d.rd  = inst[11:7];
                d.imm = {inst[31:12], 12'b0};
            end
            OpcJal: begin
                d.vld = 1'b1;
                d.op  = OpJal;
                d.rd  = inst[11:7];
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OpcJalr: begin
                d.vld = (f3 == 3'b000);
                d.op  = OpJalr;
                d.rd  = inst[11:7];
                d.rs1 = inst[19:15];
                d.imm = {{20{inst[31]}}, inst[31:20]};
            end
            OpcBranch: begin
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                d.vld = 1'b1;
                case (f3)
                    3'b000:  d.op = OpBeq;
                    3'b001:  d.op = OpBne;
                    3'b100:  d.op = OpBlt;
                    3'b101:  d.op = OpBge;
                    3'b110:  d.op = OpBltu;
                    3'b111:  d.op = OpBgeu;
                    default: d.vld = 1'b0;
                endcase
            end
            OpcLoad: begin
                d.rd  = inst[11:7];
                d.rs1 = inst[19:15];
                d.imm = {{20{inst[31]}}, inst[31:20]};
                d.vld = 1'b1;
                case (f3)
                    3'b000:  d.op = OpLb;
                    3'b001:  d.op = OpLh;
                    3'b010:  d.op = OpLw;
                    3'b100:  d.op = OpLbu;
                    3'b101:  d.op = OpLhu;
                    default: d.vld = 1'b0;
                endcase
            end
            OpcStore: begin
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.vld = 1'b1;
                case (f3)
                    3'b000:  d.op = OpSb;
                    3'b001:  d.op = OpSh;
                    3'b010:  d.op = OpSw;
                    default: d.vld = 1'b0;
                endcase
            end
            OpcOpImm: begin
                d.rd  = inst[11:7];
                d.rs1 = inst[19:15];
                d.imm = {{20{inst[31]}}, inst[31:20]};
                d.vld = 1'b1;
                case (f3)
                    3'b000: d.op = OpAddi;
                    3'b010: d.op = OpSlti;
                    3'b011: d.op = OpSltiu;
                    3'b100: d.op = OpXori;
                    3'b110: d.op = OpOri;
                    3'b111: d.op = OpAndi;
                    3'b001: begin
                        // shift amount is the raw 5-bit shamt, not a signed immediate
                        d.op  = OpSlli;
                        d.imm = {27'b0, inst[24:20]};
                        d.vld = (f7 == Funct7Base);
                    end
                    default: begin
                        d.imm = {27'b0, inst[24:20]};
                        d.op  = inst[30] ? OpSrai : OpSrli;
                        d.vld = (f7 == Funct7Base) || (f7 == Funct7Alt);
                    end
                endcase
            end
            OpcOp: begin
                d.rd  = inst[11:7];
                d.rs1 = inst[19:15];
                d.rs2 = inst[24:20];
                d.vld = 1'b1;
                if (f7 == Funct7Base) begin
                    case (f3)
                        3'b000:  d.op = OpAdd;
                        3'b001:  d.op = OpSll;
                        3'b010:  d.op = OpSlt;
                        3'b011:  d.op = OpSltu;
                        3'b100:  d.op = OpXor;
                        3'b101:  d.op = OpSrl;
                        3'b110:  d.op = OpOr;
                        default: d.op = OpAnd;
                    endcase
                end else if (f7 == Funct7Alt && f3 == 3'b000) begin
                    d.op = OpSub;
                end else if (f7 == Funct7Alt && f3 == 3'b101) begin
                    d.op = OpSra;
                end else begin
                    d.vld = 1'b0;
                end
            end
            default: d.vld = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/inst_decoder_fifo.sv
// Purpose : circular {pc,inst} buffer with push/pop/flush; head entry is visible combinationally.
// Latency : an entry pushed at edge N is at the head (readable) right after edge N.
// Backpr. : full blocks push (even with a same-cycle pop); pop on empty is ignored.
// Ports   : clk, rst (sync, active-low), flush, push/push_dat, pop, head_dat, full, empty.
module inst_fifo
    import inst_decoder_pkg::*;
#(
    parameter int Depth  = QueueDepth,
    parameter int PtrLen = QueuePtrLen
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] push_dat,
    input  logic        pop,
    output logic [63:0] head_dat,
    output logic        full,
    output logic        empty
);

    logic [63:0]       mem [Depth];
    logic [PtrLen-1:0] head;
    logic [PtrLen-1:0] tail;
    logic [PtrLen:0]   count;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == (PtrLen+1)'(Depth));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[head];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst && !flush && push_ok) mem[tail] <= push_dat;
    end

endmodule

// File: rtl/inst_decoder.sv
// Purpose : buffers fetched {pc,inst}, decodes one RV32I instruction per cycle, registers it to rf.
// Latency : push at edge N -> decoded outputs registered at edge N+1 at the earliest.
// Backpr. : ROB stall holds the head in place; is_full_to_fetch tells fetch to hold.
// Ports   : clk, rst (sync, active-low); ROB exception/stall; fetch valid/inst/pc, full;
//           rf empty/op/rd/rs1/rs2/imm/pc.
module inst_decoder
    import inst_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        is_exception_from_rob,
    input  logic        is_stall_from_rob,
    input  logic        is_valid_from_fetch,
    input  logic [31:0] inst_from_fetch,
    input  logic [31:0] pc_from_fetch,
    output logic        is_full_to_fetch,
    output logic        is_empty_to_rf,
    output logic [5:0]  op_to_rf,
    output logic [4:0]  rd_to_rf,
    output logic [4:0]  rs1_to_rf,
    output logic [4:0]  rs2_to_rf,
    output logic [31:0] imm_to_rf,
    output logic [31:0] pc_to_rf
);

    logic [63:0] head_dat;
    logic        fifo_empty;
    logic        issue;
    dec_t        dec;

    inst_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (is_exception_from_rob),
        .push     (is_valid_from_fetch),
        .push_dat ({pc_from_fetch, inst_from_fetch}),
        .pop      (!is_stall_from_rob),
        .head_dat (head_dat),
        .full     (is_full_to_fetch),
        .empty    (fifo_empty)
    );

    assign dec   = decode(head_dat[31:0]);
    assign issue = !fifo_empty && !is_stall_from_rob;

    // An unknown instruction is still popped, but the cycle reads as empty
    // and the previously issued fields are held.
    always_ff @(posedge clk) begin
        if (!rst || is_exception_from_rob) begin
            is_empty_to_rf <= 1'b1;
            op_to_rf       <= '0;
            rd_to_rf       <= '0;
            rs1_to_rf      <= '0;
            rs2_to_rf      <= '0;
            imm_to_rf      <= '0;
            pc_to_rf       <= '0;
        end else if (issue && dec.vld) begin
            is_empty_to_rf <= 1'b0;
            op_to_rf       <= dec.op;
            rd_to_rf       <= dec.rd;
            rs1_to_rf      <= dec.rs1;
            rs2_to_rf      <= dec.rs2;
            imm_to_rf      <= dec.imm;
            pc_to_rf       <= head_dat[63:32];
        end else begin
            is_empty_to_rf <= 1'b1;
        end
    end

endmodule
